// File: rtl/fft_r22sdf_ctrl.sv
// Frame sequencer for an R2^2 SDF FFT pipeline: input framing, datapath reset, output tagging.
// Define FFT_R22SDF_CTRL_BITREV_EN to report idx_o as the bit-reversed (natural-order) bin number.
module fft_r22sdf_ctrl #(
  parameter int unsigned FFT_N     = 1024,
  parameter int unsigned FFT_NLOG2 = 10,
  parameter int unsigned PIPE_LAT  = 1033,
  parameter int unsigned PEND_W    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 dp_rst_n_o,
  output logic [FFT_NLOG2-1:0] cnt_o,
  output logic                 valid_o,
  output logic                 sof_o,
  output logic                 eof_o,
  output logic [FFT_NLOG2-1:0] idx_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned          LAT_W    = $clog2(PIPE_LAT);
  localparam logic [FFT_NLOG2-1:0] CNT_LAST = FFT_NLOG2'(FFT_N - 1);
  localparam logic [FFT_NLOG2-1:0] C_ONE    = FFT_NLOG2'(1);
  localparam logic [PEND_W-1:0]    P_ONE    = PEND_W'(1);
  localparam logic [LAT_W-1:0]     LAT_LOAD = LAT_W'(PIPE_LAT - 2);

  typedef enum logic [2:0] {S_IDLE, S_DPRST, S_RUN, S_DRAIN, S_ERR} state_t;

  state_t               r_state;
  logic                 r_ready;
  logic                 r_dp_rst_n;
  logic [FFT_NLOG2-1:0] r_cnt;
  logic                 r_first;
  logic                 r_busy;
  logic                 r_err;
  logic [PEND_W-1:0]    r_pend;
  logic [LAT_W-1:0]     r_lat;
  logic                 r_lat_run;
  logic                 r_oval;
  logic [FFT_NLOG2-1:0] r_ocnt;
  logic                 r_sof;
  logic                 r_eof;
  logic [FFT_NLOG2-1:0] r_idx;

  logic                 w_accept;
  logic                 w_last_in;
  logic                 w_lat_hit;
  logic                 w_out_stop;
  logic [PEND_W-1:0]    w_pend_n;
  logic                 w_oval_n;
  logic [FFT_NLOG2-1:0] w_ocnt_n;
  logic [FFT_NLOG2-1:0] w_idx_n;

`ifdef FFT_R22SDF_CTRL_BITREV_EN
  function automatic logic [FFT_NLOG2-1:0] f_bitrev(input logic [FFT_NLOG2-1:0] v);
    logic [FFT_NLOG2-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < FFT_NLOG2; b++) r[b] = v[FFT_NLOG2-1-b];
    return r;
  endfunction
  assign w_idx_n = f_bitrev(w_ocnt_n);
`else
  assign w_idx_n = w_ocnt_n;
`endif

  assign w_accept   = (r_state == S_RUN) && valid_i;
  assign w_last_in  = w_accept && (r_cnt == CNT_LAST);
  assign w_lat_hit  = r_lat_run && (r_lat == '0);
  // Output stops only once the input side has finished and the last pending frame leaves.
  assign w_out_stop = r_eof && (r_state == S_DRAIN) && (r_pend == P_ONE);

  always_comb begin
    w_pend_n = r_pend;
    if (w_last_in && !r_eof)      w_pend_n = r_pend + P_ONE;
    else if (!w_last_in && r_eof) w_pend_n = r_pend - P_ONE;
    w_oval_n = (r_oval && !w_out_stop) || w_lat_hit;
    w_ocnt_n = '0;
    if (w_oval_n && r_oval) w_ocnt_n = r_ocnt + C_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_dp_rst_n <= 1'b0;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_pend     <= '0;
      r_lat      <= '0;
      r_lat_run  <= 1'b0;
      r_oval     <= 1'b0;
      r_ocnt     <= '0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_pend <= w_pend_n;
      r_oval <= w_oval_n;
      r_ocnt <= w_ocnt_n;
      r_sof  <= w_oval_n && (w_ocnt_n == '0);
      r_eof  <= w_oval_n && (w_ocnt_n == CNT_LAST);
      r_idx  <= w_idx_n;
      if (r_lat_run) begin
        if (r_lat == '0) r_lat_run <= 1'b0;
        else             r_lat     <= r_lat - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_DPRST;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_first <= 1'b1;
          end
        end
        S_DPRST: begin
          r_state    <= S_RUN;
          r_ready    <= 1'b1;
          r_dp_rst_n <= 1'b1;
        end
        S_RUN: begin
          if (!valid_i) begin
            r_state    <= S_ERR;
            r_ready    <= 1'b0;
            r_dp_rst_n <= 1'b0;
            r_err      <= 1'b1;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_pend     <= '0;
            r_lat      <= '0;
            r_lat_run  <= 1'b0;
            r_oval     <= 1'b0;
            r_ocnt     <= '0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_idx      <= '0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
            if (r_first) begin
              r_first   <= 1'b0;
              r_lat     <= LAT_LOAD;
              r_lat_run <= 1'b1;
            end
            if ((r_cnt == CNT_LAST) && !start_i) begin
              r_state <= S_DRAIN;
              r_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (w_out_stop) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_dp_rst_n <= 1'b0;
          end
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n && w_last_in && !r_eof) assert (r_pend != '1);
  end

  assign ready_o    = r_ready;
  assign dp_rst_n_o = r_dp_rst_n;
  assign cnt_o      = r_cnt;
  assign valid_o    = r_oval;
  assign sof_o      = r_sof;
  assign eof_o      = r_eof;
  assign idx_o      = r_idx;
  assign busy_o     = r_busy;
  assign err_o      = r_err;

endmodule
